// File: rtl/multi_ch_playback_pkg.sv
// Shared types for the multi-channel pattern playback block: FSM encoding and
// the bit positions of the rising-edge-detected GPIO strobes.
package multi_ch_playback_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int STB_WADDR  = 0;
  localparam int STB_WRAM   = 1;
  localparam int STB_BOUNDS = 2;
  localparam int STB_EN     = 3;
  localparam int NUM_STB    = 4;
endpackage

// File: rtl/multi_ch_pattern_ram.sv
// Simple dual-port pattern store: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module ch_pattern_ram #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [NUM_CH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [NUM_CH-1:0] o_rdata
);
  logic [NUM_CH-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/multi_ch_playback.sv
// Pattern playback: words loaded over GPIO into RAM are replayed onto NUM_CH
// channels over a start/stop window with a per-sample prescaler and loop count.
module multi_ch_playback
  import multi_ch_playback_pkg::*;
#(
  parameter int                NUM_CH   = 8,
  parameter int                ADDR_W   = 10,
  parameter int                PRESC_W  = 16,
  parameter int                LOOP_W   = 16,
  parameter logic [NUM_CH-1:0] IDLE_VAL = '0
) (
  input  logic               s_axi_clk,
  input  logic               s_axi_reset,
  input  logic               i_gpio_mode,
  input  logic [ADDR_W-1:0]  i_gpio_set_ram_addr,
  input  logic               i_gpio_write_addr,
  input  logic [NUM_CH-1:0]  i_gpio_din,
  input  logic               i_gpio_write_ram,
  input  logic [ADDR_W-1:0]  i_gpio_start_addr,
  input  logic [ADDR_W-1:0]  i_gpio_stop_addr,
  input  logic               i_gpio_write_bounds,
  input  logic [PRESC_W-1:0] i_gpio_prescale,
  input  logic [LOOP_W-1:0]  i_gpio_loop_count,
  input  logic               i_gpio_playback_en,
  output logic [NUM_CH-1:0]  ch_out,
  output logic [ADDR_W-1:0]  o_gpio_addr_readback,
  output logic               o_gpio_playback_done,
  output logic               o_gpio_busy,
  output logic [LOOP_W-1:0]  o_gpio_loops_done,
  output logic               o_gpio_bounds_err
);
  typedef struct packed {
    logic [ADDR_W-1:0]  start;
    logic [ADDR_W-1:0]  stop;
    logic [PRESC_W-1:0] presc;
    logic [LOOP_W-1:0]  lcnt;
  } bnd_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_STB-1:0]   r_stb_s, r_stb_d, w_rise;
  logic [ADDR_W-1:0]    r_wptr, w_waddr;
  bnd_t                 r_bnd;
  logic [ADDR_W-1:0]    r_rd_addr, r_q_addr, r_out_addr, w_next_addr;
  logic                 r_out_vld;
  logic [PRESC_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]    r_ch_out, w_rdata;
  logic                 r_done, r_berr;
  logic [LOOP_W-1:0]    r_loops;
  logic [LOOP_W:0]      w_loops_p1;
  logic                 w_load_mode, w_we, w_abort;
  logic                 w_go, w_berr, w_rd_en, w_load, w_pass_end, w_last;

  assign w_rise      = r_stb_s & ~r_stb_d;
  assign w_load_mode = (r_state == ST_IDLE) && !i_gpio_mode;
  assign w_we        = w_load_mode && w_rise[STB_WRAM];
  // A same-cycle address load redirects the write to the new pointer.
  assign w_waddr     = w_rise[STB_WADDR] ? i_gpio_set_ram_addr : r_wptr;
  assign w_abort     = !i_gpio_playback_en || !i_gpio_mode;
  assign w_next_addr = (r_rd_addr == r_bnd.stop) ? r_bnd.start : r_rd_addr + ADDR_W'(1);
  assign w_loops_p1  = {1'b0, r_loops} + (LOOP_W+1)'(1);

  ch_pattern_ram #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_ram (
    .i_clk   (s_axi_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_gpio_din),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
    if (!s_axi_reset) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_berr      = 1'b0;
    w_rd_en     = 1'b0;
    w_load      = 1'b0;
    w_pass_end  = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise[STB_EN] && i_gpio_mode) begin
          if (r_bnd.start <= r_bnd.stop) begin
            w_go        = 1'b1;
            w_state_nxt = ST_PRIME;
          end else begin
            w_berr = 1'b1;
          end
        end
      end
      ST_PRIME: begin
        if (w_abort) w_state_nxt = ST_IDLE;
        else begin
          w_rd_en     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_abort) w_state_nxt = ST_IDLE;
        else if (r_cnt == '0) begin
          // Sample boundary: the prefetched word (already wrapped) goes out
          // unless this was the final cycle of the last pass.
          w_pass_end = r_out_vld && (r_out_addr == r_bnd.stop);
          w_last     = w_pass_end && (r_bnd.lcnt != '0) && (w_loops_p1 >= {1'b0, r_bnd.lcnt});
          if (w_last) w_state_nxt = ST_DONE;
          else begin
            w_load  = 1'b1;
            w_rd_en = 1'b1;
          end
        end
      end
      ST_DONE: if (!i_gpio_playback_en) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
    if (!s_axi_reset) begin
      r_stb_s    <= '0;
      r_stb_d    <= '0;
      r_wptr     <= '0;
      r_bnd      <= '0;
      r_rd_addr  <= '0;
      r_q_addr   <= '0;
      r_out_addr <= '0;
      r_out_vld  <= 1'b0;
      r_cnt      <= '0;
      r_ch_out   <= IDLE_VAL;
      r_done     <= 1'b0;
      r_berr     <= 1'b0;
      r_loops    <= '0;
    end else begin
      r_stb_s <= {i_gpio_playback_en, i_gpio_write_bounds, i_gpio_write_ram, i_gpio_write_addr};
      r_stb_d <= r_stb_s;

      if ((w_load_mode && w_rise[STB_WADDR]) || w_we)
        r_wptr <= w_waddr + (w_we ? ADDR_W'(1) : ADDR_W'(0));
      if ((r_state == ST_IDLE) && w_rise[STB_BOUNDS])
        r_bnd <= {i_gpio_start_addr, i_gpio_stop_addr, i_gpio_prescale, i_gpio_loop_count};

      if (w_go) r_rd_addr <= r_bnd.start;
      else if (w_rd_en) begin
        r_rd_addr <= w_next_addr;
        r_q_addr  <= r_rd_addr;
      end

      if (w_go) begin
        r_out_addr <= r_bnd.start;
        r_out_vld  <= 1'b0;
        r_cnt      <= '0;
        r_done     <= 1'b0;
        r_berr     <= 1'b0;
        r_loops    <= '0;
      end
      if (w_berr) r_berr <= 1'b1;

      if (w_load) begin
        r_out_addr <= r_q_addr;
        r_out_vld  <= 1'b1;
        r_cnt      <= r_bnd.presc;
      end else if ((w_state_nxt == ST_RUN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - PRESC_W'(1);
      end

      if (w_pass_end && !(&r_loops)) r_loops <= r_loops + LOOP_W'(1);
      if (w_last) r_done <= 1'b1;

      if (w_state_nxt != ST_RUN) r_ch_out <= IDLE_VAL;
      else if (w_load)           r_ch_out <= w_rdata;
    end
  end

  assign ch_out               = r_ch_out;
  assign o_gpio_addr_readback = (r_state == ST_IDLE) ? r_wptr : r_out_addr;
  assign o_gpio_playback_done = r_done;
  assign o_gpio_busy          = (r_state == ST_PRIME) || (r_state == ST_RUN);
  assign o_gpio_loops_done    = r_loops;
  assign o_gpio_bounds_err    = r_berr;
endmodule

// File: tb/tb_multi_ch_playback.sv
module tb_multi_ch_playback;
  logic        clk, rst_n;
  logic        mode, waddr, wram, wbnd, en;
  logic [9:0]  set_addr, start_a, stop_a;
  logic [7:0]  din;
  logic [15:0] presc, lcnt;
  logic [7:0]  ch_out;
  logic [9:0]  rb;
  logic        done, busy, berr;
  logic [15:0] loops;

  multi_ch_playback dut (
    .s_axi_clk            (clk),
    .s_axi_reset          (rst_n),
    .i_gpio_mode          (mode),
    .i_gpio_set_ram_addr  (set_addr),
    .i_gpio_write_addr    (waddr),
    .i_gpio_din           (din),
    .i_gpio_write_ram     (wram),
    .i_gpio_start_addr    (start_a),
    .i_gpio_stop_addr     (stop_a),
    .i_gpio_write_bounds  (wbnd),
    .i_gpio_prescale      (presc),
    .i_gpio_loop_count    (lcnt),
    .i_gpio_playback_en   (en),
    .ch_out               (ch_out),
    .o_gpio_addr_readback (rb),
    .o_gpio_playback_done (done),
    .o_gpio_busy          (busy),
    .o_gpio_loops_done    (loops),
    .o_gpio_bounds_err    (berr)
  );

  typedef struct {
    int         at;
    string      nm;
    logic [7:0] ch;
    logic       busy;
    logic       done;
    logic       berr;
    int         loops;
    int         rb;
  } exp_t;

  exp_t exp_q[$];
  int   ecnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] pat [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt++;

  always @(negedge clk) begin
    exp_t e;
    logic bad;
    while (exp_q.size() != 0 && exp_q[0].at <= ecnt) begin
      e = exp_q.pop_front();
      bad = (e.at != ecnt) || (ch_out !== e.ch) || (busy !== e.busy) || (done !== e.done) ||
            (berr !== e.berr) || (e.loops >= 0 && loops !== 16'(e.loops)) ||
            (e.rb >= 0 && rb !== 10'(e.rb));
      n_chk++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s edge %0d (now %0d): got ch=%h busy=%b done=%b berr=%b loops=%0d rb=%0d, want ch=%h busy=%b done=%b berr=%b loops=%0d rb=%0d",
                 e.nm, e.at, ecnt, ch_out, busy, done, berr, loops, rb,
                 e.ch, e.busy, e.done, e.berr, e.loops, e.rb);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int at, input string nm, input logic [7:0] c, input logic b,
                      input logic d, input logic be, input int l, input int r);
    exp_t e;
    e.at = at; e.nm = nm; e.ch = c; e.busy = b; e.done = d; e.berr = be; e.loops = l; e.rb = r;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0:       waddr = v;
      1:       wram  = v;
      default: wbnd  = v;
    endcase
  endtask

  task automatic pulse(input int which, input int hold);
    drive(which, 1'b1);
    tick(hold);
    drive(which, 1'b0);
    tick(2);
  endtask

  task automatic set_bounds(input int s, input int e, input int p, input int l);
    start_a = 10'(s); stop_a = 10'(e); presc = 16'(p); lcnt = 16'(l);
    pulse(2, 1);
  endtask

  initial begin
    int t0, t1;
    rst_n = 1'b0; mode = 1'b0; waddr = 1'b0; wram = 1'b0; wbnd = 1'b0; en = 1'b0;
    set_addr = '0; start_a = '0; stop_a = '0; din = '0; presc = '0; lcnt = '0;
    tick(3);
    rst_n = 1'b1;
    push(ecnt, "reset", 8'h00, 0, 0, 0, 0, 0);
    tick(1);

    set_addr = 10'd0;
    pulse(0, 1);
    for (int i = 0; i < 4; i++) begin
      din = pat[i];
      pulse(1, (i == 1) ? 3 : 1);
    end
    push(ecnt, "load_rb", 8'h00, 0, 0, 0, 0, 4);
    tick(1);

    set_bounds(0, 3, 0, 1);
    mode = 1'b1;
    tick(1);
    t0 = ecnt; en = 1'b1;
    push(t0 + 1, "t2_sample_en", 8'h00, 0, 0, 0, 0, -1);
    push(t0 + 2, "t2_prime", 8'h00, 1, 0, 0, 0, -1);
    push(t0 + 3, "t2_run0", 8'h00, 1, 0, 0, 0, -1);
    for (int k = 0; k < 4; k++) push(t0 + 4 + k, "t2_smp", pat[k], 1, 0, 0, 0, k);
    push(t0 + 8, "t2_done", 8'h00, 0, 1, 0, 1, -1);
    tick(8);
    en = 1'b0;
    push(t0 + 9, "t2_idle", 8'h00, 0, 1, 0, 1, 4);
    tick(2);

    set_bounds(0, 3, 2, 2);
    t0 = ecnt; en = 1'b1;
    push(t0 + 2, "t3_prime", 8'h00, 1, 0, 0, 0, -1);
    for (int k = 0; k < 24; k++) push(t0 + 4 + k, "t3_smp", pat[(k / 3) % 4], 1, 0, 0, k / 12, -1);
    push(t0 + 28, "t3_done", 8'h00, 0, 1, 0, 2, -1);
    tick(28);
    en = 1'b0;
    tick(2);

    set_bounds(0, 3, 0, 0);
    t0 = ecnt; en = 1'b1;
    for (int k = 0; k < 10; k++) push(t0 + 4 + k, "t4_smp", pat[k % 4], 1, 0, 0, k / 4, k % 4);
    tick(13);
    en = 1'b0;
    push(t0 + 14, "t4_abort", 8'h00, 0, 0, 0, 2, 4);
    tick(2);
    t1 = ecnt; en = 1'b1;
    push(t1 + 4, "t4_restart", 8'h01, 1, 0, 0, 0, 0);
    push(t1 + 5, "t4_restart2", 8'h02, 1, 0, 0, 0, 1);
    tick(5);
    en = 1'b0;
    push(t1 + 6, "t4_abort2", 8'h00, 0, 0, 0, 0, 4);
    tick(2);

    set_bounds(5, 2, 0, 1);
    t0 = ecnt; en = 1'b1;
    push(t0 + 1, "t5_pre", 8'h00, 0, 0, 0, -1, -1);
    for (int k = 2; k <= 6; k++) push(t0 + k, "t5_err", 8'h00, 0, 0, 1, -1, -1);
    tick(6);
    en = 1'b0;
    tick(2);
    set_bounds(0, 3, 0, 1);
    t1 = ecnt; en = 1'b1;
    push(t1 + 1, "t5_err_held", 8'h00, 0, 0, 1, -1, -1);
    push(t1 + 2, "t5_clr", 8'h00, 1, 0, 0, 0, -1);
    push(t1 + 4, "t5_smp", 8'h01, 1, 0, 0, 0, 0);
    push(t1 + 8, "t5_done", 8'h00, 0, 1, 0, 1, -1);
    tick(8);
    en = 1'b0;
    tick(2);

    set_bounds(0, 3, 0, 0);
    t0 = ecnt; en = 1'b1;
    push(t0 + 4, "t6_smp", 8'h01, 1, 0, 0, 0, 0);
    push(t0 + 5, "t6_smp", 8'h02, 1, 0, 0, 0, 1);
    push(t0 + 6, "t6_async_rst", 8'h00, 0, 0, 0, 0, 0);
    tick(6);
    rst_n = 1'b0; en = 1'b0;
    #1;
    n_chk++;
    if (ch_out !== 8'h00) begin
      n_fail++;
      $display("FAIL t6_arst_ch: got %h", ch_out);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_arst_busy: got %b", busy);
    end
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_arst_done: got %b", done);
    end
    n_chk++;
    if (loops !== 16'd0) begin
      n_fail++;
      $display("FAIL t6_arst_loops: got %0d", loops);
    end
    n_chk++;
    if (rb !== 10'd0) begin
      n_fail++;
      $display("FAIL t6_arst_rb: got %0d", rb);
    end
    n_chk++;
    if (berr !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_arst_berr: got %b", berr);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    set_bounds(0, 3, 0, 1);
    t1 = ecnt; en = 1'b1;
    for (int k = 0; k < 4; k++) push(t1 + 4 + k, "t6_replay", pat[k], 1, 0, 0, 0, k);
    push(t1 + 8, "t6_done", 8'h00, 0, 1, 0, 1, -1);
    tick(8);
    en = 1'b0;
    tick(3);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s edge %0d: never checked, monitor at edge %0d", e.nm, e.at, ecnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_ch_playback.md
Name: multi_ch_playback

Overview:
- Parametrised successor to the single-channel playback unit: stores NUM_CH-bit pattern words in on-chip RAM and plays them onto NUM_CH parallel channel outputs.
- Playback runs over a programmable start/stop window, with a programmable rate prescaler and a loop counter (0 = infinite).
- Single clock domain. All controls arrive as AXI-GPIO levels from the PS; strobes are rising-edge detected internally.

Parameters:
- NUM_CH, 8: channel count and RAM word width.
- ADDR_W, 10: RAM address width; depth is 2**ADDR_W.
- PRESC_W, 16: prescaler width.
- LOOP_W, 16: loop-count width.
- IDLE_VAL, 0: NUM_CH-bit value driven on ch_out when not playing.

Ports:
- s_axi_clk  in  1  sole clock.
- s_axi_reset  in  1  asynchronous, active-low reset.
- i_gpio_mode  in  1  0 = load, 1 = playback.
- i_gpio_set_ram_addr  in  ADDR_W  write-pointer value.
- i_gpio_write_addr  in  1  strobe: load write pointer from i_gpio_set_ram_addr.
- i_gpio_din  in  NUM_CH  data word to store.
- i_gpio_write_ram  in  1  strobe: RAM[wptr] <= din, then wptr++.
- i_gpio_start_addr  in  ADDR_W  first address of the playback window.
- i_gpio_stop_addr  in  ADDR_W  last address (inclusive) of the playback window.
- i_gpio_write_bounds  in  1  strobe: latch start, stop, prescale and loop count.
- i_gpio_prescale  in  PRESC_W  each sample is held for prescale+1 cycles.
- i_gpio_loop_count  in  LOOP_W  number of passes; 0 = infinite.
- i_gpio_playback_en  in  1  level; a rising edge starts playback, low aborts.
- ch_out  out  NUM_CH  registered channel outputs.
- o_gpio_addr_readback  out  ADDR_W  write pointer when IDLE; address of the sample on ch_out otherwise.
- o_gpio_playback_done  out  1  level; set on normal completion.
- o_gpio_busy  out  1  high in PRIME and RUN.
- o_gpio_loops_done  out  LOOP_W  number of completed passes.
- o_gpio_bounds_err  out  1  sticky flag: start > stop at start attempt.

Behaviour:
- Reset (async assert): all outputs go to 0 (ch_out = IDLE_VAL); wptr, bounds registers, edge detectors and FSM are cleared; state = IDLE. RAM contents are not cleared.
- Strobe handling: each strobe is registered and acts once, on the first cycle sampled high after being sampled low. Holding a strobe high for N cycles gives one action.
- Load mode:
  - write_addr and write_ram act only in IDLE with mode = 0; they are ignored otherwise.
  - wptr wraps from 2**ADDR_W-1 to 0.
  - Same-cycle write_addr and write_ram: the write uses the newly loaded address, then increments.
- write_bounds acts only in IDLE; it is ignored otherwise.
- FSM states: IDLE, PRIME, RUN, DONE.
  - IDLE -> PRIME on a playback_en rise with mode = 1 and start <= stop. This also clears done, loops_done and bounds_err. RAM read of start is issued.
  - IDLE -> IDLE with bounds_err = 1 if start > stop at the rise.
  - PRIME -> RUN after the 1-cycle synchronous RAM read.
  - Latency: ch_out = RAM[start] exactly 3 cycles after the clock edge that samples playback_en high.
- RUN:
  - Each sample is held for prescale+1 cycles. The next address is prefetched so there are no gap cycles, including at prescale = 0 and across the stop -> start wrap.
  - After the stop sample's final cycle, loops_done increments.
  - If loop_count = 0, or loops_done+1 < loop_count, wrap to start; otherwise go to DONE.
- DONE: ch_out = IDLE_VAL and done = 1 from the cycle after the last sample. Return to IDLE when playback_en goes low; done stays set until the next start.
- Abort: playback_en low or mode = 0 during PRIME or RUN -> IDLE on the next cycle, ch_out = IDLE_VAL, done not set, loops_done retained.
- Single-sample window (start = stop): that sample is held for (prescale+1) x loop_count cycles.
- loops_done saturates at 2**LOOP_W-1 in infinite mode.

Decomposition:
- Package multi_ch_playback_pkg: FSM state enum (IDLE, PRIME, RUN, DONE) and state-width constant.
- Sub-module ch_pattern_ram: simple dual-port RAM, 2**ADDR_W x NUM_CH, write port plus synchronous 1-cycle read port, inferable as BRAM, no reset on the array.

Test Plan (NUM_CH = 8, ADDR_W = 10):
1. Load: set_ram_addr = 0, then write 0x01, 0x02, 0x04, 0x08 with one strobe each (one strobe held 3 cycles) -> readback = 4; no extra write from the held strobe.
2. Bounds 0..3, prescale 0, loop 1, en rise -> ch_out = 01, 02, 04, 08 on consecutive cycles starting 3 cycles after the rise; then 00; done = 1 and loops_done = 1 in the same cycle as 00.
3. Prescale 2, loop 2 -> each value held 3 cycles, two passes (24 cycles); 08 -> 01 wrap has no gap; then done.
4. Loop 0, deassert en after 10 RUN cycles -> ch_out = 00 on the next cycle, busy = 0, done = 0; a new rise restarts from RAM[0].
5. start = 5, stop = 2, en rise -> bounds_err = 1, busy never asserts, ch_out stays 00; a valid write_bounds plus rise clears the error.
6. Async reset low mid-RUN -> outputs 0 immediately without a clock edge; after release, replaying 0..3 gives 01, 02, 04, 08 (RAM retained).
